bram_port_arbiter: RTL

- Shares one single-port synchronous BRAM (1-cycle registered read, read-first on write) between two requesters, A and B.
- Grants at most one access per cycle using round-robin arbitration.
- Returns read data to the granted requester with a matching valid strobe.
- Sits between two client datapaths and the BRAM macro, driving its we/addr/din and consuming its dout.

---
 rtl/bram_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//   Shares one single-port synchronous BRAM (1-cycle registered read,
//   read-first on write) between two requesters, A and B. At most one
//   access is issued per cycle. When both sides request, either A always
//   wins (PRIORITY_A=1) or a round-robin pointer picks the winner. Read data
//   returns one cycle after the grant, steered to the issuing side by a tag
//   register.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_x/we_x/addr_x/din_x     requester x access (held until gnt_x)
//   gnt_x                       access issued this cycle (combinational)
//   rvalid_x/rdata_x            read result for requester x
//   mem_we/mem_addr/mem_din     BRAM write enable, address, write data
//   mem_dout                    BRAM registered read data
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter bit PRIORITY_A = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    side_e                 ptr_q, ptr_d;            // round-robin: side favoured on a tie
    side_e                 sel_q, sel_d;            // last issuing side, steers the idle mux
    side_e                 tag_side_q, tag_side_d;  // side owning the read in flight
    logic                  tag_valid_q, tag_valid_d;
    logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d;
    logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;
    side_e                 issue_side;

    // Arbitration. Grants are suppressed during reset so no write can
    // reach the BRAM while the block is being initialised.
    // NOTE: every signal driven here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (req_a && req_b) begin
                if (PRIORITY_A || ptr_q == SIDE_A) gnt_a = 1'b1;
                else                               gnt_b = 1'b1;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // With no grant the address/data mux keeps pointing at the last issuing
    // side, so mem_addr stays at a defined value instead of floating.
    always_comb begin
        issue_side = sel_q;
        if (gnt_a)      issue_side = SIDE_A;
        else if (gnt_b) issue_side = SIDE_B;
    end

    assign mem_addr = (issue_side == SIDE_B) ? addr_b : addr_a;
    assign mem_din  = (issue_side == SIDE_B) ? din_b  : din_a;
    assign mem_we   = (gnt_a && we_a) || (gnt_b && we_b);

    // Read return: the BRAM output is already registered, so it is passed
    // straight through in the cycle the tag says it belongs to.
    assign rvalid_a = !reset && tag_valid_q && (tag_side_q == SIDE_A);
    assign rvalid_b = !reset && tag_valid_q && (tag_side_q == SIDE_B);
    assign rdata_a  = reset ? '0 : (rvalid_a ? mem_dout : hold_a_q);
    assign rdata_b  = reset ? '0 : (rvalid_b ? mem_dout : hold_b_q);

    always_comb begin
        ptr_d       = ptr_q;
        if (gnt_a)      ptr_d = SIDE_B;
        else if (gnt_b) ptr_d = SIDE_A;
        sel_d       = issue_side;
        tag_valid_d = (gnt_a || gnt_b) && !mem_we;
        tag_side_d  = issue_side;
        hold_a_d    = rvalid_a ? mem_dout : hold_a_q;
        hold_b_d    = rvalid_b ? mem_dout : hold_b_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: only control state is reset; the BRAM contents live outside
    // this block and are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= SIDE_A;
            sel_q       <= SIDE_A;
            tag_valid_q <= 1'b0;
            tag_side_q  <= SIDE_A;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            tag_valid_q <= tag_valid_d;
            tag_side_q  <= tag_side_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
        end
    end

endmodule
